// File: rtl/lamp_log_issue_ctrl.sv
// rtl/lamp_log_issue_ctrl.sv - bfloat16 operand issue / result capture front-end for lampFPU_log
// Optional watchdog (timeout_o output) is built only when LAMP_LOG_TIMEOUT_EN is defined.
module lamp_log_issue_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  output logic        op_ready_o,
  input  logic [15:0] op_i,
  output logic        doLog_o,
  output logic        s_op_o,
  output logic [7:0]  e_op_o,
  output logic [6:0]  f_op_o,
  output logic        isZ_op_o,
  output logic        isInf_op_o,
  output logic        isSNAN_op_o,
  output logic        isQNAN_op_o,
  output logic        isDN_op_o,
  input  logic        s_res_i,
  input  logic [7:0]  e_res_i,
  input  logic [6:0]  f_res_i,
  input  logic        valid_i,
  input  logic        isOverflow_i,
  input  logic        isUnderflow_i,
  input  logic        isToRound_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [15:0] res_o,
  output logic [2:0]  res_flags_o,
  output logic        busy_o
`ifdef LAMP_LOG_TIMEOUT_EN
  ,
  output logic        timeout_o
`endif
);

  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = PTR_W + 1;
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("lamp_log_issue_ctrl: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t             state_q, state_d;
  logic [15:0]        op_q;
  logic               op_loaded_q;
  logic               run_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [18:0]        mem_q [FIFO_DEPTH];

  logic        accept, push, pop, req_done, gap_last, timeout_hit;
  logic [18:0] push_data;
  logic [7:0]  op_e;
  logic [6:0]  op_f;

  assign accept   = op_valid_i & op_ready_o;
  assign pop      = res_valid_o & res_ready_i;
  assign req_done = (state_q == REQ) & (valid_i | timeout_hit);
  assign push     = req_done;
  assign gap_last = (gap_cnt_q == GAP_W'(GAP_LAST));

  // A real result always wins over a watchdog expiry in the same cycle.
  assign push_data = timeout_hit ? {16'h7FC0, 3'b000}
                                 : {s_res_i, e_res_i, f_res_i, isOverflow_i, isUnderflow_i, isToRound_i};

`ifdef LAMP_LOG_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wd_cnt_q;

  assign timeout_hit = (state_q == REQ) & ~valid_i & (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q  <= '0;
      timeout_o <= 1'b0;
    end else begin
      wd_cnt_q  <= (state_q == REQ && !req_done) ? wd_cnt_q + WD_W'(1) : '0;
      timeout_o <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept)   state_d = REQ;
      REQ:  if (req_done) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:  if (gap_last) state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  // Credit check: in IDLE nothing is outstanding, so the FIFO count alone decides.
  always_comb begin
    doLog_o    = 1'b0;
    op_ready_o = 1'b0;
    busy_o     = (count_q != '0);
    case (state_q)
      IDLE: op_ready_o = run_q & (count_q < CNT_W'(FIFO_DEPTH));
      REQ: begin
        doLog_o = 1'b1;
        busy_o  = 1'b1;
      end
      GAP:  busy_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q       <= 1'b0;
      op_q        <= '0;
      op_loaded_q <= 1'b0;
      gap_cnt_q   <= '0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        op_q        <= op_i;
        op_loaded_q <= 1'b1;
      end
      gap_cnt_q <= (state_q == GAP && !gap_last) ? gap_cnt_q + GAP_W'(1) : '0;
    end
  end

  assign op_e   = op_q[14:7];
  assign op_f   = op_q[6:0];
  assign s_op_o = op_q[15];
  assign e_op_o = op_e;
  assign f_op_o = op_f;

  // Flags are masked until an operand has been loaded so reset drives them all low.
  assign isInf_op_o  = op_loaded_q & (&op_e) & ~(|op_f);
  assign isQNAN_op_o = op_loaded_q & (&op_e) & (|op_f) & op_f[6];
  assign isSNAN_op_o = op_loaded_q & (&op_e) & (|op_f) & ~op_f[6];
  assign isZ_op_o    = op_loaded_q & ~(|op_e) & ~(|op_f);
  assign isDN_op_o   = op_loaded_q & ~(|op_e) & (|op_f);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign res_valid_o = (count_q != '0);
  assign res_o       = res_valid_o ? mem_q[rd_ptr_q][18:3] : '0;
  assign res_flags_o = res_valid_o ? mem_q[rd_ptr_q][2:0]  : '0;

endmodule

// File: tb/tb_lamp_log_issue_ctrl.sv
// tb/tb_lamp_log_issue_ctrl.sv - directed self-checking bench for lamp_log_issue_ctrl
module tb_lamp_log_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid_i;
  logic        op_ready_o;
  logic [15:0] op_i;
  logic        doLog_o;
  logic        s_op_o;
  logic [7:0]  e_op_o;
  logic [6:0]  f_op_o;
  logic        isZ_op_o, isInf_op_o, isSNAN_op_o, isQNAN_op_o, isDN_op_o;
  logic        s_res_i;
  logic [7:0]  e_res_i;
  logic [6:0]  f_res_i;
  logic        valid_i;
  logic        isOverflow_i, isUnderflow_i, isToRound_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [15:0] res_o;
  logic [2:0]  res_flags_o;
  logic        busy_o;
`ifdef LAMP_LOG_TIMEOUT_EN
  logic        timeout_o;
`endif

  int checks   = 0;
  int failures = 0;

  logic model_en;
  logic model_valid;
  logic spur;
  int   lat_cfg;
  int   lat;

  always #5 clk = ~clk;

  lamp_log_issue_ctrl #(
    .FIFO_DEPTH(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_i(op_i),
    .doLog_o(doLog_o), .s_op_o(s_op_o), .e_op_o(e_op_o), .f_op_o(f_op_o),
    .isZ_op_o(isZ_op_o), .isInf_op_o(isInf_op_o), .isSNAN_op_o(isSNAN_op_o),
    .isQNAN_op_o(isQNAN_op_o), .isDN_op_o(isDN_op_o),
    .s_res_i(s_res_i), .e_res_i(e_res_i), .f_res_i(f_res_i), .valid_i(valid_i),
    .isOverflow_i(isOverflow_i), .isUnderflow_i(isUnderflow_i), .isToRound_i(isToRound_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_o(res_o), .res_flags_o(res_flags_o), .busy_o(busy_o)
`ifdef LAMP_LOG_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );

  // Log unit model: result derived from the presented operand, valid after lat_cfg cycles.
  assign s_res_i       = ~s_op_o;
  assign e_res_i       = e_op_o ^ 8'h5A;
  assign f_res_i       = f_op_o + 7'd1;
  assign isOverflow_i  = e_op_o[0];
  assign isUnderflow_i = f_op_o[0];
  assign isToRound_i   = s_op_o;
  assign valid_i       = model_valid | spur;

  always @(negedge clk) begin
    if (!model_en || !doLog_o) begin
      lat         = 0;
      model_valid = 1'b0;
    end else begin
      model_valid = (lat == lat_cfg);
      lat         = lat + 1;
    end
  end

  logic [15:0] tbl_op  [5];
  logic [4:0]  tbl_cls [5];
  logic [15:0] tbl_res [5];
  logic [2:0]  tbl_flg [5];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] cls_vec();
    return {isZ_op_o, isInf_op_o, isSNAN_op_o, isQNAN_op_o, isDN_op_o};
  endfunction

  task automatic send_op(input logic [15:0] op);
    int n = 0;
    op_valid_i = 1'b1;
    op_i       = op;
    while (!op_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_op_ready", 32'(op_ready_o), 32'd1);
    @(negedge clk);
    op_valid_i = 1'b0;
  endtask

  task automatic pop_one();
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
  endtask

  task automatic issue_and_check(input logic [15:0] op, input logic [4:0] ecls,
                                 input logic [15:0] eres, input logic [2:0] eflg);
    int run = 0;
    send_op(op);
    check("dolog_rise", 32'(doLog_o), 32'd1);
    check("class_flags", 32'(cls_vec()), 32'(ecls));
    check("operand_out", 32'({s_op_o, e_op_o, f_op_o}), 32'(op));
    while (doLog_o && run < 100) begin
      run++;
      @(negedge clk);
    end
    check("dolog_high_cycles", 32'(run), 32'(lat_cfg + 1));
    check("res_valid", 32'(res_valid_o), 32'd1);
    check("res_value", 32'(res_o), 32'(eres));
    check("res_flags", 32'(res_flags_o), 32'(eflg));
    pop_one();
    check("single_entry", 32'(res_valid_o), 32'd0);
  endtask

  initial begin
    int n;
    int low;
    tbl_op[0] = 16'h0000; tbl_cls[0] = 5'b10000; tbl_res[0] = 16'hAD01; tbl_flg[0] = 3'b000;
    tbl_op[1] = 16'h0001; tbl_cls[1] = 5'b00001; tbl_res[1] = 16'hAD02; tbl_flg[1] = 3'b010;
    tbl_op[2] = 16'h7F80; tbl_cls[2] = 5'b01000; tbl_res[2] = 16'hD281; tbl_flg[2] = 3'b100;
    tbl_op[3] = 16'h7FC1; tbl_cls[3] = 5'b00010; tbl_res[3] = 16'hD2C2; tbl_flg[3] = 3'b110;
    tbl_op[4] = 16'h7F81; tbl_cls[4] = 5'b00100; tbl_res[4] = 16'hD282; tbl_flg[4] = 3'b110;

    rst = 1'b0; op_valid_i = 1'b0; op_i = '0; res_ready_i = 1'b0;
    model_en = 1'b1; spur = 1'b0; lat_cfg = 3;
    repeat (3) @(negedge clk);

    check("rst_dolog", 32'(doLog_o), 32'd0);
    check("rst_op_ready", 32'(op_ready_o), 32'd0);
    check("rst_res_valid", 32'(res_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_res", 32'({res_o, res_flags_o}), 32'd0);
    check("rst_class", 32'(cls_vec()), 32'd0);
    check("rst_operand", 32'({s_op_o, e_op_o, f_op_o}), 32'd0);
    rst = 1'b1;

    // 1.0 through a 3-cycle unit
    issue_and_check(16'h3F80, 5'b00000, 16'h9281, 3'b100);

    // class sweep
    lat_cfg = 1;
    for (int i = 0; i < 5; i++) issue_and_check(tbl_op[i], tbl_cls[i], tbl_res[i], tbl_flg[i]);

    // back-pressure: four fill the FIFO, the fifth is held off
    for (int i = 0; i < 4; i++) send_op(tbl_op[i]);
    repeat (8) @(negedge clk);
    check("full_op_ready", 32'(op_ready_o), 32'd0);
    check("full_res_valid", 32'(res_valid_o), 32'd1);
    op_valid_i = 1'b1;
    op_i       = tbl_op[4];
    repeat (4) @(negedge clk);
    check("full_held_off", 32'(doLog_o), 32'd0);
    check("pop_order_0", 32'(res_o), 32'(tbl_res[0]));
    res_ready_i = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      if (doLog_o) op_valid_i = 1'b0;
      check($sformatf("pop_order_%0d", k), 32'(res_o), 32'(tbl_res[k]));
    end
    @(negedge clk);
    res_ready_i = 1'b0;
    if (doLog_o) op_valid_i = 1'b0;
    n = 0;
    while (!res_valid_o && n < 100) begin
      @(negedge clk);
      if (doLog_o) op_valid_i = 1'b0;
      n++;
    end
    op_valid_i = 1'b0;
    check("fifth_res", 32'(res_o), 32'(tbl_res[4]));
    check("fifth_flags", 32'(res_flags_o), 32'(tbl_flg[4]));
    pop_one();
    check("fifth_drained", 32'(res_valid_o), 32'd0);

    // spurious valid during GAP is not captured
    lat_cfg = 2;
    send_op(tbl_op[0]);
    n = 0;
    while (doLog_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    spur = 1'b1;
    repeat (2) @(negedge clk);
    spur = 1'b0;
    check("spur_res", 32'(res_o), 32'(tbl_res[0]));
    pop_one();
    check("spur_ignored", 32'(res_valid_o), 32'd0);

    // issue-to-issue spacing with the operand held valid
    op_valid_i = 1'b1;
    op_i       = 16'h3F80;
    n = 0;
    while (!doLog_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (doLog_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    low = 0;
    while (!doLog_o && low < 50) begin
      @(negedge clk);
      low++;
    end
    op_valid_i = 1'b0;
    check("gap_low_cycles", 32'(low), 32'd3);
    n = 0;
    while (doLog_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("spacing_res_a", 32'(res_o), 32'h9281);
    pop_one();
    check("spacing_res_b", 32'(res_o), 32'h9281);
    pop_one();
    check("spacing_drained", 32'(res_valid_o), 32'd0);

    // reset in the middle of a request
    model_en = 1'b0;
    send_op(16'h7F80);
    repeat (3) @(negedge clk);
    check("stuck_req", 32'(doLog_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_dolog", 32'(doLog_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_res_valid", 32'(res_valid_o), 32'd0);
    @(negedge clk);
    rst  = 1'b1;
    spur = 1'b1;
    repeat (2) @(negedge clk);
    spur = 1'b0;
    check("late_valid_ignored", 32'(res_valid_o), 32'd0);
    check("late_valid_busy", 32'(busy_o), 32'd0);
    model_en = 1'b1;
    lat_cfg  = 3;
    issue_and_check(16'h3F80, 5'b00000, 16'h9281, 3'b100);

`ifdef LAMP_LOG_TIMEOUT_EN
    model_en = 1'b0;
    send_op(16'h3F80);
    n = 0;
    while (!timeout_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd16);
    check("timeout_res", 32'(res_o), 32'h7FC0);
    check("timeout_flags", 32'(res_flags_o), 32'd0);
    @(negedge clk);
    check("timeout_pulse", 32'(timeout_o), 32'd0);
    pop_one();
    model_en = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
